// File: rtl/addr0_buf0.sv
// Pixel line buffer: DEPTH x 24-bit RGB storage addressed by an
// auto-incrementing, wrapping address counter. Read data is registered.
module addr0_buf0 #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       WData,
    input  logic              WE0,
    input  logic              RE0,
    input  logic              IncAddr0,
    input  logic              ResetAddr0,
    output logic [ADDR_W-1:0] Addr0,
    output logic [7:0]        R0,
    output logic [7:0]        G0,
    output logic [7:0]        B0,
    output logic              LastAddr0
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PIX_W = 24;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [PIX_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] addr_nxt_c;
    logic [IDX_W-1:0]  idx_c;
    logic              wr_en_c;
    logic [PIX_W-1:0]  rd_pix;
    logic              unused_wdata_hi;

    // The alpha/pad byte of the write word carries no information.
    assign unused_wdata_hi = ^WData[31:24];

    // Counter never exceeds DEPTH-1, so the low bits select the entry.
    assign idx_c = Addr0[IDX_W-1:0];

    // Writes are blocked while reset is held.
    assign wr_en_c = reset & WE0;

    // Next counter value: clear beats increment, increment wraps at the last entry.
    always_comb begin
        addr_nxt_c = Addr0;
        if (ResetAddr0) begin
            addr_nxt_c = '0;
        end else if (IncAddr0) begin
            if (Addr0 == LAST_ADDR) begin
                addr_nxt_c = '0;
            end else begin
                addr_nxt_c = Addr0 + ADDR_W'(1);
            end
        end
    end

    // Address counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Addr0 <= '0;
        end else begin
            Addr0 <= addr_nxt_c;
        end
    end

    // Pixel storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[idx_c] <= WData[PIX_W-1:0];
        end
    end

    // Registered read port; old contents are returned on a same-cycle write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pix <= '0;
        end else if (RE0) begin
            rd_pix <= mem[idx_c];
        end
    end

    assign R0 = rd_pix[23:16];
    assign G0 = rd_pix[15:8];
    assign B0 = rd_pix[7:0];

    // Flags the final entry of the buffer.
    assign LastAddr0 = (Addr0 == LAST_ADDR);

endmodule

// File: tb/tb_addr0_buf0.sv
// Directed bench for addr0_buf0 with a read-data scoreboard.
module tb_addr0_buf0;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic [31:0]       WData;
    logic              WE0;
    logic              RE0;
    logic              IncAddr0;
    logic              ResetAddr0;
    logic [ADDR_W-1:0] Addr0;
    logic [7:0]        R0;
    logic [7:0]        G0;
    logic [7:0]        B0;
    logic              LastAddr0;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];
    logic        rd_q = 1'b0;

    addr0_buf0 #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .WData(WData), .WE0(WE0), .RE0(RE0),
        .IncAddr0(IncAddr0), .ResetAddr0(ResetAddr0), .Addr0(Addr0),
        .R0(R0), .G0(G0), .B0(B0), .LastAddr0(LastAddr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clocked operation; inputs drop back to idle just after the edge.
    task automatic step(input logic we, input logic re, input logic inc, input logic clr,
                        input logic [31:0] wd, input logic [23:0] exp_rd);
        @(negedge clk);
        WE0 = we; RE0 = re; IncAddr0 = inc; ResetAddr0 = clr; WData = wd;
        if (re) exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        WE0 = 1'b0; RE0 = 1'b0; IncAddr0 = 1'b0; ResetAddr0 = 1'b0; WData = 32'h0;
    endtask

    task automatic chk_addr(input string name, input logic [ADDR_W-1:0] exp_a);
        chk(name, 32'(Addr0), 32'(exp_a));
        chk({name, "_last"}, 32'(LastAddr0), 32'(exp_a == ADDR_W'(DEPTH - 1)));
    endtask

    // Note which edges performed a read.
    always @(posedge clk) rd_q <= reset & RE0;

    // Scoreboard: compare read data one cycle after each read edge.
    always @(negedge clk) begin
        if (rd_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected none", {R0, G0, B0});
            end else begin
                chk("rd_data", 32'({R0, G0, B0}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; WData = 32'h0; WE0 = 1'b0; RE0 = 1'b0;
        IncAddr0 = 1'b0; ResetAddr0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_addr("rst_addr", '0);
        chk("rst_rgb", 32'({R0, G0, B0}), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Write two pixels, rewind, read them back
        step(1, 0, 1, 0, 32'h00AABBCC, 24'h0);
        step(1, 0, 1, 0, 32'h00112233, 24'h0);
        chk_addr("wr_addr2", 2);
        step(0, 0, 0, 1, 32'h0, 24'h0);
        chk_addr("rewind", 0);
        step(0, 1, 1, 0, 32'h0, 24'hAABBCC);
        step(0, 1, 1, 0, 32'h0, 24'h112233);
        chk_addr("rd_addr2", 2);

        // Clear has priority over increment
        step(0, 0, 1, 1, 32'h0, 24'h0);
        chk_addr("prio", 0);

        // Same-cycle write and read returns the old word
        step(1, 0, 0, 0, 32'h00010203, 24'h0);
        step(1, 1, 0, 0, 32'h00FFEEDD, 24'h010203);
        step(0, 1, 0, 0, 32'h0, 24'hFFEEDD);

        // Read data holds while the counter moves
        step(1, 0, 0, 0, 32'h00445566, 24'h0);
        step(0, 1, 1, 0, 32'h0, 24'h445566);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 32'h0, 24'h0);
            chk("hold_rgb", 32'({R0, G0, B0}), 32'h445566);
        end
        chk_addr("hold_addr", 0);

        // Wrap: five increments from 0; the fourth also writes entry 3
        step(0, 0, 1, 0, 32'h0, 24'h0);
        chk_addr("wrap1", 1);
        step(0, 0, 1, 0, 32'h0, 24'h0);
        chk_addr("wrap2", 2);
        step(0, 0, 1, 0, 32'h0, 24'h0);
        chk_addr("wrap3", 3);
        step(1, 0, 1, 0, 32'h00777777, 24'h0);
        chk_addr("wrap0", 0);
        step(0, 0, 1, 0, 32'h0, 24'h0);
        chk_addr("wrap1b", 1);

        // Reset mid-operation with a write pending at entry 3
        step(0, 1, 1, 0, 32'h0, 24'h112233);
        step(0, 0, 1, 0, 32'h0, 24'h0);
        chk_addr("pre_rst", 3);
        @(negedge clk);
        WE0 = 1'b1; IncAddr0 = 1'b1; WData = 32'h00999999;
        #1;
        reset = 1'b0;
        #1;
        chk_addr("async_rst", 0);
        chk("async_rst_rgb", 32'({R0, G0, B0}), 32'h0);
        @(posedge clk);
        #1;
        chk_addr("rst_hold", 0);
        WE0 = 1'b0; IncAddr0 = 1'b0; WData = 32'h0;
        @(negedge clk);
        reset = 1'b1;

        // Memory survived reset and the blocked write did not land
        step(0, 1, 1, 0, 32'h0, 24'h445566);
        step(0, 0, 1, 0, 32'h0, 24'h0);
        step(0, 0, 1, 0, 32'h0, 24'h0);
        chk_addr("post_rst3", 3);
        step(0, 1, 0, 0, 32'h0, 24'h777777);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr0_buf0.md
ADDR0_BUF0 -- requirements
Module: addr0_buf0

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20: width of the address counter.
REQ-002 The block SHALL have parameter DEPTH, default 1024: number of pixel entries stored; SHALL satisfy 2 <= DEPTH <= 2**ADDR_W.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port WData, input, 32 bits: write pixel word; [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored.
REQ-006 Port WE0, input, 1 bit: write enable.
REQ-007 Port RE0, input, 1 bit: read enable.
REQ-008 Port IncAddr0, input, 1 bit: advance address counter.
REQ-009 Port ResetAddr0, input, 1 bit: synchronous clear of address counter.
REQ-010 Port Addr0, output, ADDR_W bits: current buffer address (counter value).
REQ-011 Port R0, output, 8 bits: red component of last read pixel.
REQ-012 Port G0, output, 8 bits: green component of last read pixel.
REQ-013 Port B0, output, 8 bits: blue component of last read pixel.
REQ-014 Port LastAddr0, output, 1 bit: high while Addr0 == DEPTH-1 (combinational from counter).

Function
REQ-015 Storage SHALL be DEPTH entries x 24 bits; only the counter-selected entry is accessed each cycle.
REQ-016 Write: on rising clk with WE0=1, mem[Addr0] <= WData[23:0].
REQ-017 Read: on rising clk with RE0=1, {R0,G0,B0} <= mem[Addr0]; one-cycle latency.
REQ-018 With RE0=0, R0/G0/B0 SHALL hold their previous values.
REQ-019 WE0=1 and RE0=1 in the same cycle: write occurs and the read returns the OLD contents (read-before-write).
REQ-020 Counter: ResetAddr0=1 loads 0 at the next edge, taking priority over IncAddr0.
REQ-021 Counter: IncAddr0=1 (ResetAddr0=0) increments Addr0 by 1 at the next edge; otherwise Addr0 holds.
REQ-022 Wrap-around: IncAddr0 at Addr0 == DEPTH-1 loads 0; Addr0 SHALL never exceed DEPTH-1.
REQ-023 Read/write in a cycle with IncAddr0=1 use the pre-increment Addr0.
REQ-024 The same block, renamed signal-for-signal (Addr1, WE1, RE1, IncAddr1, ResetAddr1, R1/G1/B1), SHALL serve buffer 1; no behavioural difference.

Reset
REQ-025 reset=0 SHALL immediately, without clk, force Addr0=0 and R0=G0=B0=0; LastAddr0 follows Addr0.
REQ-026 Memory contents SHALL NOT be cleared by reset; writes and reads are suppressed while reset=0.
REQ-027 Reset asserted mid-operation SHALL abort the current access; after release the counter restarts at 0.

Verification
REQ-028 Reset: drive reset=0 with Addr0=5, R0=0x12 -> Addr0=0, R0/G0/B0=0 before the next clk edge.
REQ-029 Write/read: write 0x00AABBCC at Addr0=0, 0x00112233 at Addr0=1 (WE0+IncAddr0), ResetAddr0, then RE0+IncAddr0 for two cycles -> {R0,G0,B0}=AA,BB,CC then 11,22,33, each one cycle after its read cycle.
REQ-030 Wrap: DEPTH=4, pulse IncAddr0 5 times from 0 -> Addr0 sequence 1,2,3,0,1; LastAddr0=1 only while Addr0=3.
REQ-031 Priority: ResetAddr0=1 and IncAddr0=1 together at Addr0=2 -> Addr0=0.
REQ-032 Collision: mem[0]=0x00010203, WE0=RE0=1 with WData=0x00FFEEDD at Addr0=0 -> R0/G0/B0=01/02/03; subsequent read -> FF/EE/DD.
REQ-033 Hold: RE0=0 for 3 cycles after a read of 0x00445566 -> R0/G0/B0 stay 44/55/66 while Addr0 changes.
